// File: rtl/i2s_rx_deserializer.sv
// ----------------------------------------------------------------------------
// i2s_rx_deserializer: I2S receiver, SCK oversampled by clk_i, stereo pair out
// with valid/ready handshake.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module i2s_rx_deserializer #(
  parameter int   DATA_W = 24,
  parameter int   SLOT_W = 32,
  parameter logic WS_POL = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sck_i,
  input  logic              ws_i,
  input  logic              sd_i,
  input  logic              ready_i,
  output logic [DATA_W-1:0] left_o,
  output logic [DATA_W-1:0] right_o,
  output logic              valid_o,
  output logic              overrun_o,
  output logic              frame_err_o
);

  localparam int               CNT_W    = $clog2(SLOT_W + 1);
  localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SLOT_W);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  state_t            state_q;
  logic              sck_q;
  logic              ws_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] left_q;
  logic [DATA_W-1:0] right_q;
  logic [DATA_W-1:0] word_d;
  logic              valid_q;
  logic              overrun_q;
  logic              frame_err_q;
  logic              rise;
  logic              ws_edge;
  logic              to_left;
  logic              short_slot;

  // Only the low cnt_q bits of the shifter belong to the current slot, so the
  // left shift both discards stale bits and zero-pads a short word.
  always_comb begin
    rise       = sck_i & ~sck_q;
    ws_edge    = rise & (ws_i != ws_q);
    to_left    = (ws_i == WS_POL);
    short_slot = (cnt_q < CNT_DATA);
    cnt_d      = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
    shift_d    = DATA_W'({shift_q, sd_i});
    word_d     = short_slot ? (shift_q << (CNT_DATA - cnt_q)) : shift_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= SYNC;
      sck_q       <= 1'b0;
      ws_q        <= WS_POL;
      cnt_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sck_q       <= sck_i;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      if (valid_q && ready_i) valid_q <= 1'b0;
      if (rise) ws_q <= ws_i;

      case (state_q)
        SYNC: begin
          if (ws_edge && to_left) begin
            state_q <= LEFT;
            cnt_q   <= '0;
          end
        end
        LEFT: begin
          if (ws_edge && !to_left) begin
            hold_q      <= word_d;
            frame_err_q <= short_slot;
            cnt_q       <= '0;
            state_q     <= RIGHT;
          end else if (rise && !ws_edge) begin
            if (short_slot) shift_q <= shift_d;
            cnt_q <= cnt_d;
          end
        end
        RIGHT: begin
          if (ws_edge && to_left) begin
            frame_err_q <= short_slot;
            cnt_q       <= '0;
            state_q     <= LEFT;
            // A pending unaccepted pair wins; the fresh one is dropped.
            if (valid_q && !ready_i) begin
              overrun_q <= 1'b1;
            end else begin
              left_q  <= hold_q;
              right_q <= word_d;
              valid_q <= 1'b1;
            end
          end else if (rise && !ws_edge) begin
            if (short_slot) shift_q <= shift_d;
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= SYNC;
      endcase
    end
  end

  assign left_o      = left_q;
  assign right_o     = right_q;
  assign valid_o     = valid_q;
  assign overrun_o   = overrun_q;
  assign frame_err_o = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_i2s_rx_deserializer.sv
// ----------------------------------------------------------------------------
// tb_i2s_rx_deserializer: scoreboard bench for the I2S receiver (SCK = clk/8).
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_i2s_rx_deserializer;

  localparam int DW = 24;
  localparam int SW = 32;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          sck_i;
  logic          ws_i;
  logic          sd_i;
  logic          ready_i;
  logic [DW-1:0] left_o;
  logic [DW-1:0] right_o;
  logic          valid_o;
  logic          overrun_o;
  logic          frame_err_o;

  int checks  = 0;
  int errors  = 0;
  int ovr_cnt = 0;
  int fe_cnt  = 0;

  logic [2*DW-1:0] sb[$];
  logic [2*DW-1:0] mon_exp;

  i2s_rx_deserializer #(
    .DATA_W(DW),
    .SLOT_W(SW),
    .WS_POL(1'b0)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .sck_i      (sck_i),
    .ws_i       (ws_i),
    .sd_i       (sd_i),
    .ready_i    (ready_i),
    .left_o     (left_o),
    .right_o    (right_o),
    .valid_o    (valid_o),
    .overrun_o  (overrun_o),
    .frame_err_o(frame_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired got timeout required finish");
    $fatal(1, "watchdog");
  end

  // Every accepted transfer is checked against the oldest expected pair.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (overrun_o) ovr_cnt++;
      if (frame_err_o) fe_cnt++;
      if (valid_o && ready_i) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL pair_unexpected got %h/%h required none", left_o, right_o);
        end else begin
          mon_exp = sb.pop_front();
          if ({left_o, right_o} !== mon_exp) begin
            errors++;
            $display("FAIL pair_data got %h/%h required %h/%h",
                     left_o, right_o, mon_exp[2*DW-1:DW], mon_exp[DW-1:0]);
          end
        end
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sck_edge_begin(input logic ws, input logic sd);
    ws_i  = ws;
    sd_i  = sd;
    sck_i = 1'b0;
    clks(4);
    sck_i = 1'b1;
  endtask

  task automatic sck_bit(input logic ws, input logic sd);
    sck_edge_begin(ws, sd);
    clks(4);
  endtask

  // First SCK of a slot carries the WS change; data MSB follows on the next.
  task automatic send_slot(input logic lvl, input logic [DW-1:0] word, input int nsck);
    logic b;
    sck_bit(lvl, 1'b0);
    for (int i = 1; i < nsck; i++) begin
      b = 1'b0;
      if (i <= DW) b = word[DW-i];
      sck_bit(lvl, b);
    end
  endtask

  function automatic logic [DW-1:0] exp_word(input logic [DW-1:0] w, input int nsck);
    int            cap;
    logic [DW-1:0] m;
    cap = (nsck - 1 < DW) ? nsck - 1 : DW;
    m   = '1;
    m   = m << (DW - cap);
    return w & m;
  endfunction

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                            input int lsck, input int rsck, input bit keep);
    send_slot(1'b0, l, lsck);
    send_slot(1'b1, r, rsck);
    if (keep) sb.push_back({exp_word(l, lsck), exp_word(r, rsck)});
  endtask

  task automatic rst_pulse();
    sck_i = 1'b0;
    ws_i  = 1'b1;
    sd_i  = 1'b0;
    rst_i = 1'b1;
    clks(2);
    rst_i = 1'b0;
    clks(1);
  endtask

  task automatic wait_drain();
    repeat (40) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    clks(3);
    checks++; if (left_o !== '0)      begin errors++; $display("FAIL reset_left got %h required 0", left_o); end
    checks++; if (right_o !== '0)     begin errors++; $display("FAIL reset_right got %h required 0", right_o); end
    checks++; if (valid_o !== 1'b0)   begin errors++; $display("FAIL reset_valid got %b required 0", valid_o); end
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b required 0", overrun_o); end
    checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b required 0", frame_err_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_basic();
    int fe0;
    ready_i = 1'b1;
    rst_pulse();
    fe0 = fe_cnt;
    send_slot(1'b1, '0, SW);
    send_frame(24'hABCDEF, 24'h123456, SW, SW, 1'b1);
    sck_edge_begin(1'b0, 1'b0);
    @(negedge clk);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL basic_valid_early got %b required 0", valid_o); end
    @(negedge clk);
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid_timing got %b required 1", valid_o); end
    clks(4);
    wait_drain();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL basic_drain got %0d required 0", sb.size()); end
    checks++; if (fe_cnt - fe0 != 0) begin errors++; $display("FAIL basic_frame_err got %0d required 0", fe_cnt - fe0); end
  endtask

  task automatic test_overrun();
    int ov0;
    ready_i = 1'b0;
    rst_pulse();
    ov0 = ovr_cnt;
    send_slot(1'b1, '0, SW);
    send_frame(24'h000001, 24'h000002, SW, SW, 1'b1);
    send_frame(24'h000003, 24'h000004, SW, SW, 1'b0);
    sck_bit(1'b0, 1'b0);
    clks(2);
    checks++; if (ovr_cnt - ov0 != 1) begin errors++; $display("FAIL ovr_pulses got %0d required 1", ovr_cnt - ov0); end
    checks++; if (left_o !== 24'h000001) begin errors++; $display("FAIL ovr_left_hold got %h required 000001", left_o); end
    checks++; if (right_o !== 24'h000002) begin errors++; $display("FAIL ovr_right_hold got %h required 000002", right_o); end
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL ovr_valid_hold got %b required 1", valid_o); end
    ready_i = 1'b1;
    wait_drain();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL ovr_drain got %0d required 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    int ov0;
    ready_i = 1'b0;
    rst_pulse();
    ov0 = ovr_cnt;
    send_slot(1'b1, '0, SW);
    send_frame(24'h0A0A0A, 24'h0B0B0B, SW, SW, 1'b1);
    send_frame(24'h0C0C0C, 24'h0D0D0D, SW, SW, 1'b1);
    sck_edge_begin(1'b0, 1'b0);
    ready_i = 1'b1;
    @(negedge clk);
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL b2b_valid_before got %b required 1", valid_o); end
    @(negedge clk);
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL b2b_valid_after got %b required 1", valid_o); end
    checks++; if ({left_o, right_o} !== {24'h0C0C0C, 24'h0D0D0D})
      begin errors++; $display("FAIL b2b_new_pair got %h/%h required 0c0c0c/0d0d0d", left_o, right_o); end
    clks(4);
    wait_drain();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_drain got %0d required 0", sb.size()); end
    checks++; if (ovr_cnt - ov0 != 0) begin errors++; $display("FAIL b2b_overrun got %0d required 0", ovr_cnt - ov0); end
  endtask

  task automatic test_frame_err();
    int fe0;
    ready_i = 1'b1;
    rst_pulse();
    fe0 = fe_cnt;
    send_slot(1'b1, '0, SW);
    // Left slot carries only 16 data bits (all ones) after its WS edge.
    send_frame(24'hFFFF00, 24'h5A5A5A, 17, SW, 1'b1);
    sck_bit(1'b0, 1'b0);
    wait_drain();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL fe_drain got %0d required 0", sb.size()); end
    checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL fe_pulses got %0d required 1", fe_cnt - fe0); end
  endtask

  task automatic test_reset_mid();
    ready_i = 1'b1;
    sck_i   = 1'b0;
    rst_i   = 1'b1;
    send_slot(1'b0, 24'h111111, SW);
    send_slot(1'b1, 24'h222222, 16);
    rst_i = 1'b0;
    for (int i = 0; i < 16; i++) sck_bit(1'b1, i[0]);
    send_frame(24'h333333, 24'h444444, SW, SW, 1'b1);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL mid_no_partial got %b required 0", valid_o); end
    sck_bit(1'b0, 1'b0);
    wait_drain();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL mid_drain got %0d required 0", sb.size()); end
  endtask

  task automatic test_async_reset();
    ready_i = 1'b0;
    rst_pulse();
    send_slot(1'b1, '0, SW);
    send_frame(24'h7FFFFF, 24'h800000, SW, SW, 1'b1);
    sck_bit(1'b0, 1'b0);
    clks(2);
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL async_pre_valid got %b required 1", valid_o); end
    #2;
    rst_i = 1'b1;
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL async_valid got %b required 0", valid_o); end
    checks++; if (left_o !== '0)    begin errors++; $display("FAIL async_left got %h required 0", left_o); end
    checks++; if (right_o !== '0)   begin errors++; $display("FAIL async_right got %h required 0", right_o); end
    sb.delete();
    clks(2);
    rst_i = 1'b0;
    clks(2);
  endtask

  initial begin
    rst_i   = 1'b1;
    sck_i   = 1'b0;
    ws_i    = 1'b1;
    sd_i    = 1'b0;
    ready_i = 1'b1;
    test_reset();
    test_basic();
    test_overrun();
    test_back_to_back();
    test_frame_err();
    test_reset_mid();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
